// File: rtl/rv_lsu.sv
// Load/store unit between execute and a wait-stated data port: lane-aligns requests,
// extends load data, and flags misaligned, unsupported and timed-out accesses.
module rv_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    resp_misalign,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_MASK = ADDR_WIDTH'(NB - 1);
  localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // Sign- or zero-extend the low 8/16/32/DATA_WIDTH bits; funct[2] selects unsigned.
  function automatic logic [DATA_WIDTH-1:0] f_extend(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [2:0] funct);
    logic [DATA_WIDTH-1:0] v;
    logic sb;
    int bits;
    case (funct[1:0])
      2'b00:   begin bits = 8;          sb = d[7];            end
      2'b01:   begin bits = 16;         sb = d[15];           end
      2'b10:   begin bits = 32;         sb = d[31];           end
      default: begin bits = DATA_WIDTH; sb = d[DATA_WIDTH-1]; end
    endcase
    sb = sb & ~funct[2];
    v = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      v[i] = (i < bits) ? d[i] : sb;
    end
    return v;
  endfunction

  state_t                  r_state;
  logic                    r_drain;
  logic [31:0]             r_cnt;
  logic [OW-1:0]           r_off;
  logic [2:0]              r_funct;
  logic                    r_we;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [NB-1:0]           r_mem_be;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_err;
  logic                    r_resp_misalign;

  logic                    w_ready;
  logic                    w_stall;
  logic                    w_accept;
  logic [OW-1:0]           w_off;
  logic [2:0]              w_align_mask;
  logic                    w_misalign;
  logic                    w_unsup;
  int                      w_size_bytes;
  logic [NB-1:0]           w_be_base;
  logic [NB-1:0]           w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [31:0]             w_cnt_next;
  logic                    w_timeout;

  // Request decode: alignment, legality and lane placement of the incoming access.
  always_comb begin
    w_ready      = reset & (r_state == S_IDLE) & ~r_drain;
    w_stall      = reset & ((req_valid & ~w_ready) | (r_state != S_IDLE));
    w_accept     = req_valid & w_ready;
    w_off        = req_addr[OW-1:0];
    w_size_bytes = 32'd1 << req_funct[1:0];
    case (req_funct[1:0])
      2'b00:   w_align_mask = 3'b000;
      2'b01:   w_align_mask = 3'b001;
      2'b10:   w_align_mask = 3'b011;
      default: w_align_mask = 3'b111;
    endcase
    w_misalign = |(req_addr[2:0] & w_align_mask);
    w_unsup    = (req_funct == 3'b111) | (req_we & req_funct[2]) |
                 ((DATA_WIDTH == 32) & ((req_funct == 3'b011) | (req_funct == 3'b110)));
    w_be_base = '0;
    for (int i = 0; i < NB; i++) begin
      w_be_base[i] = (i < w_size_bytes);
    end
    w_be        = w_be_base << w_off;
    w_wdata     = req_wdata << {w_off, 3'b000};
    w_shifted   = mem_rdata >> {r_off, 3'b000};
    w_load_data = f_extend(w_shifted, r_funct);
    w_cnt_next  = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
    w_timeout   = (LP_TIMEOUT != 32'd0) && (w_cnt_next >= LP_TIMEOUT);
  end

  // Transaction FSM with all memory-side and response outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_drain         <= 1'b0;
      r_cnt           <= 32'd0;
      r_off           <= '0;
      r_funct         <= 3'b000;
      r_we            <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_be        <= '0;
      r_mem_wdata     <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_err      <= 1'b0;
      r_resp_misalign <= 1'b0;
    end else begin
      // A response that outlived its timeout is swallowed here, whatever the state.
      if (r_drain && mem_rvalid) begin
        r_drain <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt        <= 32'd0;
            r_off        <= w_off;
            r_funct      <= req_funct;
            r_we         <= req_we;
            r_resp_rdata <= '0;
            if (w_misalign) begin
              r_state         <= S_FAULT;
              r_resp_valid    <= 1'b1;
              r_resp_misalign <= 1'b1;
              r_resp_err      <= 1'b0;
            end else if (w_unsup) begin
              r_state         <= S_FAULT;
              r_resp_valid    <= 1'b1;
              r_resp_misalign <= 1'b0;
              r_resp_err      <= 1'b1;
            end else begin
              r_state     <= S_ISSUE;
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= req_addr & ~LP_ADDR_MASK;
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= w_cnt_next;
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT;
          end else if (w_timeout) begin
            r_mem_req    <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_next;
          if (mem_rvalid) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= mem_err;
            r_resp_rdata <= (mem_err || r_we) ? '0 : w_load_data;
          end else if (w_timeout) begin
            r_drain      <= 1'b1;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end
        end
        S_RESP, S_FAULT: begin
          r_state         <= S_IDLE;
          r_resp_valid    <= 1'b0;
          r_resp_err      <= 1'b0;
          r_resp_misalign <= 1'b0;
          r_resp_rdata    <= '0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = w_ready;
  assign stall         = w_stall;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_be        = r_mem_be;
  assign mem_wdata     = r_mem_wdata;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign resp_misalign = r_resp_misalign;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: a 32-bit instance with the default timeout and a
// 64-bit instance with TIMEOUT_CYCLES=4.
module tb_rv_lsu;

  logic clk;
  int tests;
  int failed;

  logic        a_reset, a_valid, a_we, a_gnt, a_rvalid, a_err;
  logic [2:0]  a_funct;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_ready, a_resp_valid, a_resp_err, a_resp_mis, a_stall, a_mem_req, a_mem_we;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;

  logic        c_reset, c_valid, c_we, c_gnt, c_rvalid, c_err;
  logic [2:0]  c_funct;
  logic [31:0] c_addr;
  logic [63:0] c_wdata, c_rdata;
  logic        c_ready, c_resp_valid, c_resp_err, c_resp_mis, c_stall, c_mem_req, c_mem_we;
  logic [63:0] c_resp_rdata, c_mem_wdata;
  logic [31:0] c_mem_addr;
  logic [7:0]  c_mem_be;

  rv_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) u_a (
    .clk(clk), .reset(a_reset), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_funct(a_funct), .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .resp_misalign(a_resp_mis),
    .stall(a_stall), .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_gnt(a_gnt), .mem_rvalid(a_rvalid),
    .mem_rdata(a_rdata), .mem_err(a_err)
  );

  rv_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_c (
    .clk(clk), .reset(c_reset), .req_valid(c_valid), .req_ready(c_ready), .req_we(c_we),
    .req_funct(c_funct), .req_addr(c_addr), .req_wdata(c_wdata), .resp_valid(c_resp_valid),
    .resp_rdata(c_resp_rdata), .resp_err(c_resp_err), .resp_misalign(c_resp_mis),
    .stall(c_stall), .mem_req(c_mem_req), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
    .mem_be(c_mem_be), .mem_wdata(c_mem_wdata), .mem_gnt(c_gnt), .mem_rvalid(c_rvalid),
    .mem_rdata(c_rdata), .mem_err(c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait transaction on the 32-bit instance; starts and ends at a negedge in IDLE.
  task automatic txn32(input string tag, input logic we, input logic [2:0] f,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input logic merr, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input logic [31:0] e_rd);
    a_valid = 1'b1; a_we = we; a_funct = f; a_addr = addr; a_wdata = wd;
    #1 chk({tag, ".ready"}, 64'(a_ready), 64'd1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk({tag, ".mem_req"}, 64'(a_mem_req), 64'd1);
    chk({tag, ".mem_addr"}, 64'(a_mem_addr), 64'(e_addr));
    chk({tag, ".mem_be"}, 64'(a_mem_be), 64'(e_be));
    chk({tag, ".mem_wdata"}, 64'(a_mem_wdata), 64'(e_wd));
    chk({tag, ".mem_we"}, 64'(a_mem_we), 64'(we));
    chk({tag, ".stall"}, 64'(a_stall), 64'd1);
    a_gnt = 1'b1;
    @(negedge clk);
    a_gnt = 1'b0;
    #1;
    chk({tag, ".req_drop"}, 64'(a_mem_req), 64'd0);
    chk({tag, ".early_resp"}, 64'(a_resp_valid), 64'd0);
    a_rvalid = 1'b1; a_rdata = rd; a_err = merr;
    @(negedge clk);
    a_rvalid = 1'b0; a_err = 1'b0;
    #1;
    chk({tag, ".resp_valid"}, 64'(a_resp_valid), 64'd1);
    chk({tag, ".resp_rdata"}, 64'(a_resp_rdata), 64'(e_rd));
    chk({tag, ".resp_err"}, 64'(a_resp_err), 64'(merr));
    @(negedge clk);
    #1;
    chk({tag, ".pulse_end"}, 64'(a_resp_valid), 64'd0);
    chk({tag, ".ready_next"}, 64'(a_ready), 64'd1);
  endtask

  // Request that must be rejected without touching memory.
  task automatic fault32(input string tag, input logic we, input logic [2:0] f,
                         input logic [31:0] addr, input logic e_mis, input logic e_err);
    a_valid = 1'b1; a_we = we; a_funct = f; a_addr = addr; a_wdata = 32'h0;
    #1 chk({tag, ".ready"}, 64'(a_ready), 64'd1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk({tag, ".resp_valid"}, 64'(a_resp_valid), 64'd1);
    chk({tag, ".misalign"}, 64'(a_resp_mis), 64'(e_mis));
    chk({tag, ".err"}, 64'(a_resp_err), 64'(e_err));
    chk({tag, ".rdata"}, 64'(a_resp_rdata), 64'd0);
    chk({tag, ".no_mem_req"}, 64'(a_mem_req), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, ".pulse_end"}, 64'(a_resp_valid), 64'd0);
    chk({tag, ".no_mem_req2"}, 64'(a_mem_req), 64'd0);
    chk({tag, ".ready_next"}, 64'(a_ready), 64'd1);
  endtask

  initial begin
    tests = 0; failed = 0;
    a_reset = 1'b0; a_valid = 1'b0; a_we = 1'b0; a_gnt = 1'b0; a_rvalid = 1'b0; a_err = 1'b0;
    a_funct = 3'b000; a_addr = 32'h0; a_wdata = 32'h0; a_rdata = 32'h0;
    c_reset = 1'b0; c_valid = 1'b0; c_we = 1'b0; c_gnt = 1'b0; c_rvalid = 1'b0; c_err = 1'b0;
    c_funct = 3'b000; c_addr = 32'h0; c_wdata = 64'h0; c_rdata = 64'h0;

    repeat (2) @(negedge clk);
    a_valid = 1'b1; c_valid = 1'b1;
    #1;
    chk("rst.a_ready", 64'(a_ready), 64'd0);
    chk("rst.a_stall", 64'(a_stall), 64'd0);
    chk("rst.a_mem_req", 64'(a_mem_req), 64'd0);
    chk("rst.a_resp_valid", 64'(a_resp_valid), 64'd0);
    chk("rst.a_mem_be", 64'(a_mem_be), 64'd0);
    chk("rst.c_ready", 64'(c_ready), 64'd0);
    chk("rst.c_mem_req", 64'(c_mem_req), 64'd0);
    a_valid = 1'b0; c_valid = 1'b0;
    @(negedge clk);
    a_reset = 1'b1; c_reset = 1'b1;
    @(negedge clk);

    // Zero-wait loads and stores, issued back to back.
    txn32("lb",  1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 1'b0,
          32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    txn32("lbu", 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF_1234, 1'b0,
          32'h1000, 4'b1000, 32'h0, 32'h0000_0080);
    txn32("sh",  1'b1, 3'b001, 32'h2002, 32'h0000_ABCD, 32'hDEAD_BEEF, 1'b0,
          32'h2000, 4'b1100, 32'hABCD_0000, 32'h0);
    txn32("lh",  1'b0, 3'b001, 32'h2002, 32'h0, 32'h8001_0000, 1'b0,
          32'h2000, 4'b1100, 32'h0, 32'hFFFF_8001);
    txn32("lw",  1'b0, 3'b010, 32'h0004, 32'h0, 32'h8765_4321, 1'b0,
          32'h0004, 4'b1111, 32'h0, 32'h8765_4321);

    fault32("lw_mis", 1'b0, 3'b010, 32'h3001, 1'b1, 1'b0);
    fault32("ld32",   1'b0, 3'b011, 32'h4000, 1'b0, 1'b1);
    fault32("st_f4",  1'b1, 3'b100, 32'h5000, 1'b0, 1'b1);
    fault32("f111",   1'b0, 3'b111, 32'h5000, 1'b0, 1'b1);
    fault32("mis_pri", 1'b1, 3'b101, 32'h5001, 1'b1, 1'b0);

    // Stray response while idle.
    a_rvalid = 1'b1; a_rdata = 32'h1111_1111;
    @(negedge clk);
    a_rvalid = 1'b0;
    #1 chk("idle_rvalid", 64'(a_resp_valid), 64'd0);

    // Grant withheld five cycles, then an errored response.
    a_valid = 1'b1; a_we = 1'b0; a_funct = 3'b010; a_addr = 32'h6004;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_rvalid = (i == 2);
      #1;
      chk("hold.mem_req", 64'(a_mem_req), 64'd1);
      chk("hold.mem_addr", 64'(a_mem_addr), 64'h6004);
      chk("hold.mem_be", 64'(a_mem_be), 64'hF);
      chk("hold.stall", 64'(a_stall), 64'd1);
      chk("hold.resp_valid", 64'(a_resp_valid), 64'd0);
      @(negedge clk);
    end
    a_rvalid = 1'b0; a_gnt = 1'b1;
    @(negedge clk);
    a_gnt = 1'b0;
    #1 chk("hold.req_drop", 64'(a_mem_req), 64'd0);
    a_rvalid = 1'b1; a_err = 1'b1; a_rdata = 32'h1234_5678;
    @(negedge clk);
    a_rvalid = 1'b0; a_err = 1'b0;
    #1;
    chk("merr.resp_valid", 64'(a_resp_valid), 64'd1);
    chk("merr.resp_err", 64'(a_resp_err), 64'd1);
    chk("merr.resp_rdata", 64'(a_resp_rdata), 64'd0);
    @(negedge clk);
    #1 chk("merr.pulse_end", 64'(a_resp_valid), 64'd0);

    // 64-bit LWU from the upper word.
    c_valid = 1'b1; c_we = 1'b0; c_funct = 3'b110; c_addr = 32'h8004;
    #1 chk("lwu.ready", 64'(c_ready), 64'd1);
    @(negedge clk);
    c_valid = 1'b0;
    #1;
    chk("lwu.mem_req", 64'(c_mem_req), 64'd1);
    chk("lwu.mem_addr", 64'(c_mem_addr), 64'h8000);
    chk("lwu.mem_be", 64'(c_mem_be), 64'hF0);
    c_gnt = 1'b1;
    @(negedge clk);
    c_gnt = 1'b0; c_rvalid = 1'b1; c_rdata = 64'hF000_0001_0000_0000;
    @(negedge clk);
    c_rvalid = 1'b0;
    #1;
    chk("lwu.resp_valid", 64'(c_resp_valid), 64'd1);
    chk("lwu.resp_rdata", c_resp_rdata, 64'h0000_0000_F000_0001);
    chk("lwu.resp_err", 64'(c_resp_err), 64'd0);
    @(negedge clk);
    #1 chk("lwu.pulse_end", 64'(c_resp_valid), 64'd0);

    // Timeout in WAIT, then drain of the late response.
    c_valid = 1'b1; c_funct = 3'b010; c_addr = 32'h9000;
    @(negedge clk);
    c_valid = 1'b0;
    #1 chk("to.mem_req", 64'(c_mem_req), 64'd1);
    c_gnt = 1'b1;
    @(negedge clk);
    c_gnt = 1'b0;
    #1 chk("to.wait1", 64'(c_resp_valid), 64'd0);
    @(negedge clk);
    #1 chk("to.wait2", 64'(c_resp_valid), 64'd0);
    @(negedge clk);
    #1 chk("to.wait3", 64'(c_resp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("to.resp_valid", 64'(c_resp_valid), 64'd1);
    chk("to.resp_err", 64'(c_resp_err), 64'd1);
    chk("to.resp_rdata", c_resp_rdata, 64'd0);
    c_valid = 1'b1; c_funct = 3'b100; c_addr = 32'hA000;
    @(negedge clk);
    #1;
    chk("drain.resp_valid", 64'(c_resp_valid), 64'd0);
    chk("drain.ready", 64'(c_ready), 64'd0);
    chk("drain.stall", 64'(c_stall), 64'd1);
    @(negedge clk);
    #1 chk("drain.ready2", 64'(c_ready), 64'd0);
    c_rvalid = 1'b1; c_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    c_rvalid = 1'b0;
    #1;
    chk("drain.no_resp", 64'(c_resp_valid), 64'd0);
    chk("drain.ready_back", 64'(c_ready), 64'd1);
    @(negedge clk);
    c_valid = 1'b0;
    #1;
    chk("after.mem_req", 64'(c_mem_req), 64'd1);
    chk("after.mem_addr", 64'(c_mem_addr), 64'hA000);
    chk("after.mem_be", 64'(c_mem_be), 64'h01);
    c_gnt = 1'b1;
    @(negedge clk);
    c_gnt = 1'b0;
    #1 chk("after.req_drop", 64'(c_mem_req), 64'd0);

    // Reset while in WAIT; the orphaned response must be ignored.
    c_reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rstw.mem_req", 64'(c_mem_req), 64'd0);
    chk("rstw.resp_valid", 64'(c_resp_valid), 64'd0);
    chk("rstw.ready", 64'(c_ready), 64'd0);
    chk("rstw.stall", 64'(c_stall), 64'd0);
    c_reset = 1'b1; c_rvalid = 1'b1;
    @(negedge clk);
    c_rvalid = 1'b0;
    #1;
    chk("rstw.ignored", 64'(c_resp_valid), 64'd0);
    chk("rstw.ready_back", 64'(c_ready), 64'd1);
    @(negedge clk);
    #1 chk("rstw.ignored2", 64'(c_resp_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
